// File: rtl/gates_selftest.sv
// gates_selftest: drives the gates block through all four input vectors and accumulates
// per-gate and per-vector mismatch masks into a pass/fail verdict.
module gates_selftest #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  input  logic [7:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [3:0] fail_vec
);
  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(SETTLE - 1);
  state_t r_state, w_next;
  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic [7:0] r_mask;
  logic [3:0] r_fvec;
  logic       r_pass;
  logic       w_go, w_a, w_b;
  logic [7:0] w_exp, w_diff;
  assign w_a = r_vec[1];
  assign w_b = r_vec[0];
  assign w_go = start && (r_state == IDLE || r_state == DONE);
  // bit order: buffer, xnor, xor, nor, nand, not, or, and
  assign w_exp = {w_a, ~(w_a ^ w_b), w_a ^ w_b, ~(w_a | w_b), ~(w_a & w_b), ~w_a, w_a | w_b, w_a & w_b};
  assign w_diff = gate_out ^ w_exp;
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = WAIT;
    else if (r_state == WAIT) w_next = (r_cnt == 4'd0) ? SAMPLE : WAIT;
    else if (r_state == SAMPLE) w_next = (r_vec == 2'd3) ? DONE : WAIT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= 4'd0;
      r_mask  <= 8'd0;
      r_fvec  <= 4'd0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_vec  <= 2'd0;
        r_cnt  <= LOAD;
        r_mask <= 8'd0;
        r_fvec <= 4'd0;
        r_pass <= 1'b0;
      end else if (r_state == WAIT) begin
        r_cnt <= (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
      end else if (r_state == SAMPLE) begin
        r_mask <= r_mask | w_diff;
        if (|w_diff) r_fvec[r_vec] <= 1'b1;
        if (r_vec == 2'd3) begin
          r_pass <= ~|(r_mask | w_diff);
        end else begin
          r_vec <= r_vec + 2'd1;
          r_cnt <= LOAD;
        end
      end
    end
  end
  assign in1       = r_vec[1];
  assign in2       = r_vec[0];
  assign busy      = (r_state == WAIT) || (r_state == SAMPLE);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign fail_mask = r_mask;
  assign fail_vec  = r_fvec;
endmodule

// File: tb/tb_gates_selftest.sv
// tb_gates_selftest: two controllers (SETTLE=2 and SETTLE=1) share one stimulus;
// a cycle-indexed run model is checked every cycle, directed cases pin literal results.
module tb_gates_selftest;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  int         mode = 0;
  logic       in1[2], in2[2], busy[2], done[2], pass[2];
  logic [7:0] gate_out[2], fail_mask[2];
  logic [3:0] fail_vec[2];
  int         n_cmp = 0, n_err = 0;
  logic [7:0] tt[4] = '{8'h5C, 8'h2E, 8'hAA, 8'hC3};
  always #5 clk = ~clk;
  function automatic logic [7:0] gate_fn(input logic [1:0] k, input int md);
    logic [7:0] g;
    g = tt[k];
    if (md == 1) g[0] = 1'b0;
    if (md == 2) g[6:5] = {g[5], g[6]};
    return g;
  endfunction
  assign gate_out[0] = gate_fn({in1[0], in2[0]}, mode);
  assign gate_out[1] = gate_fn({in1[1], in2[1]}, mode);
  gates_selftest #(.SETTLE(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start), .in1(in1[0]), .in2(in2[0]), .gate_out(gate_out[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail_mask(fail_mask[0]), .fail_vec(fail_vec[0])
  );
  gates_selftest #(.SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .in1(in1[1]), .in2(in2[1]), .gate_out(gate_out[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail_mask(fail_mask[1]), .fail_vec(fail_vec[1])
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: m_n is the cycle index within the current run (1..4P+1), P = SETTLE+1
  bit         m_act[2] = '{0, 0};
  int         m_n[2] = '{0, 0};
  logic [7:0] m_mask[2] = '{8'h00, 8'h00};
  logic [3:0] m_fvec[2] = '{4'h0, 4'h0};
  logic       m_pass[2] = '{1'b0, 1'b0};
  function automatic int per(input int d);
    return d == 0 ? 3 : 2;
  endfunction
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int p, k;
      logic [7:0] diff, nm;
      p = per(d);
      if (reset) begin
        m_act[d] <= 0; m_n[d] <= 0; m_mask[d] <= '0; m_fvec[d] <= '0; m_pass[d] <= 0;
      end else if (start && (!m_act[d] || m_n[d] == 4 * p + 1)) begin
        m_act[d] <= 1; m_n[d] <= 1; m_mask[d] <= '0; m_fvec[d] <= '0; m_pass[d] <= 0;
      end else if (m_act[d] && m_n[d] <= 4 * p) begin
        if (m_n[d] % p == 0) begin
          k = m_n[d] / p - 1;
          diff = gate_fn(2'(k), mode) ^ tt[k];
          nm = m_mask[d] | diff;
          m_mask[d] <= nm;
          if (diff != 0) m_fvec[d][k] <= 1'b1;
          if (k == 3) m_pass[d] <= (nm == 0);
        end
        m_n[d] <= m_n[d] + 1;
      end
    end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int p, v;
      p = per(d);
      v = !m_act[d] ? 0 : (m_n[d] > 4 * p ? 3 : (m_n[d] - 1) / p);
      chk($sformatf("d%0d_vec", d), {6'd0, in1[d], in2[d]}, 8'(v));
      chk($sformatf("d%0d_busy", d), {7'd0, busy[d]}, {7'd0, m_act[d] && m_n[d] <= 4 * p});
      chk($sformatf("d%0d_done", d), {7'd0, done[d]}, {7'd0, m_act[d] && m_n[d] == 4 * p + 1});
      chk($sformatf("d%0d_pass", d), {7'd0, pass[d]}, {7'd0, m_pass[d]});
      chk($sformatf("d%0d_mask", d), fail_mask[d], m_mask[d]);
      chk($sformatf("d%0d_fvec", d), {4'd0, fail_vec[d]}, {4'd0, m_fvec[d]});
    end
  end
  task automatic go(input int md, input logic [7:0] em, input logic [3:0] ev, input logic ep,
                    input bit repulse, input bit hold);
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = hold;
    for (int c = 2; c <= 13; c++) begin
      @(negedge clk);
      if (c == 9) begin
        chk("s1_done_c9", {7'd0, done[1]}, 8'd1);
        chk("s1_pass_c9", {7'd0, pass[1]}, {7'd0, ep});
      end
      if (c == 12) chk("s2_done_c12", {7'd0, done[0]}, 8'd0);
      if (c == 13) begin
        chk("s2_done_c13", {7'd0, done[0]}, 8'd1);
        chk("s2_busy_c13", {7'd0, busy[0]}, 8'd0);
        chk("s2_pass", {7'd0, pass[0]}, {7'd0, ep});
        chk("s2_mask", fail_mask[0], em);
        chk("s2_fvec", {4'd0, fail_vec[0]}, {4'd0, ev});
      end
      start = hold || (repulse && (c == 4 || c == 8));
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vec", {6'd0, in1[0], in2[0]}, 8'd0);
    chk("rst_busy", {7'd0, busy[0]}, 8'd0);
    chk("rst_done", {7'd0, done[0]}, 8'd0);
    chk("rst_mask", fail_mask[0], 8'h00);
    go(0, 8'h00, 4'h0, 1'b1, 0, 0);
    go(1, 8'h01, 4'b1000, 1'b0, 0, 0);
    go(2, 8'h60, 4'b1111, 1'b0, 0, 0);
    go(0, 8'h00, 4'h0, 1'b1, 1, 0);
    go(0, 8'h00, 4'h0, 1'b1, 0, 1);
    for (int c = 14; c <= 26; c++) begin
      @(negedge clk);
      if (c == 14) begin
        chk("hold_busy_c14", {7'd0, busy[0]}, 8'd1);
        chk("hold_done_c14", {7'd0, done[0]}, 8'd0);
      end
      if (c == 25) chk("hold_done_c25", {7'd0, done[0]}, 8'd0);
      if (c == 26) chk("hold_done_c26", {7'd0, done[0]}, 8'd1);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    mode = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 5; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_vec", {6'd0, in1[0], in2[0]}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy[0]}, 8'd0);
    chk("mid_rst_done", {7'd0, done[0]}, 8'd0);
    chk("mid_rst_pass", {7'd0, pass[0]}, 8'd0);
    chk("mid_rst_mask", fail_mask[0], 8'h00);
    chk("mid_rst_fvec", {4'd0, fail_vec[0]}, 8'd0);
    go(0, 8'h00, 4'h0, 1'b1, 0, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
